// File: rtl/router_dest_rx.sv
// Destination-side reader for one router output port: drains the port FIFO,
// reassembles header/payload/parity into a sop/eop byte stream and reports status.
module router_dest_rx #(
  parameter int READ_DELAY = 2,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vld_out,
  input  logic [DW-1:0] data_out,
  input  logic          hold_in,
  output logic          read_enb,
  output logic [DW-1:0] rx_data,
  output logic          rx_data_vld,
  output logic          rx_sop,
  output logic          rx_eop,
  output logic [1:0]    pkt_addr,
  output logic [5:0]    pkt_len,
  output logic          pkt_done,
  output logic          parity_err,
  output logic          abort,
  output logic          busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [4:0] DLY = 5'(READ_DELAY);

  logic [2:0]    state, state_nxt;
  logic [4:0]    dly_cnt;
  logic [6:0]    issued, issued_nxt, cap_idx, total, issue_lim;
  logic          hdr_known, hdr_now, known, rd_d1;
  logic [5:0]    len_cur;
  logic [DW-1:0] par;
  logic          pending, in_flight, last_cap, abort_c, rd_next;

  // The header can be used in the very cycle it is captured, so issue never
  // stalls waiting for the length to land in pkt_len.
  assign hdr_now    = rd_d1 && (cap_idx == 7'd0);
  assign len_cur    = hdr_now ? data_out[7:2] : pkt_len;
  assign known      = hdr_known || hdr_now;
  assign total      = {1'b0, len_cur} + 7'd2;
  assign issue_lim  = known ? total : 7'd2;
  assign issued_nxt = issued + {6'd0, read_enb};
  assign pending    = !known || (issued < total);
  assign in_flight  = read_enb || rd_d1;
  assign last_cap   = rd_d1 && hdr_known && (cap_idx == total - 7'd1);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    abort_c   = 1'b0;
    case (state)
      S_IDLE:  if (vld_out) state_nxt = (READ_DELAY == 0) ? S_READ : S_WAIT;
      S_WAIT: begin
        if (!vld_out)              state_nxt = S_IDLE;
        else if (dly_cnt <= 5'd1)  state_nxt = S_READ;
      end
      S_READ: begin
        if (last_cap)                             state_nxt = S_DONE;
        else if (known && issued_nxt >= total)    state_nxt = S_DRAIN;
        else if (!vld_out && pending && !in_flight) begin
          // FIFO vanished with nothing outstanding: router soft-reset it
          state_nxt = S_IDLE;
          abort_c   = 1'b1;
        end
      end
      S_DRAIN: if (last_cap) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_next = (state_nxt == S_READ) && !hold_in && vld_out && (issued_nxt < issue_lim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      dly_cnt     <= '0;
      issued      <= '0;
      cap_idx     <= '0;
      hdr_known   <= 1'b0;
      rd_d1       <= 1'b0;
      par         <= '0;
      read_enb    <= 1'b0;
      rx_data     <= '0;
      rx_data_vld <= 1'b0;
      rx_sop      <= 1'b0;
      rx_eop      <= 1'b0;
      pkt_addr    <= '0;
      pkt_len     <= '0;
      pkt_done    <= 1'b0;
      parity_err  <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state       <= state_nxt;
      read_enb    <= rd_next;
      rd_d1       <= read_enb;
      abort       <= abort_c;
      pkt_done    <= (state_nxt == S_DONE);
      parity_err  <= (state_nxt == S_DONE) && (par != data_out);
      rx_data_vld <= rd_d1;
      rx_sop      <= hdr_now;
      rx_eop      <= last_cap;

      if (state == S_IDLE)                      dly_cnt <= DLY;
      else if (state == S_WAIT && dly_cnt != 0) dly_cnt <= dly_cnt - 5'd1;

      if (rd_d1) begin
        rx_data <= data_out;
        cap_idx <= cap_idx + 7'd1;
        par     <= hdr_now ? data_out : (par ^ data_out);
        if (hdr_now) begin
          pkt_addr  <= data_out[1:0];
          pkt_len   <= data_out[7:2];
          hdr_known <= 1'b1;
        end
      end

      if (state == S_IDLE) begin
        issued    <= '0;
        cap_idx   <= '0;
        hdr_known <= 1'b0;
        par       <= '0;
      end else begin
        issued    <= issued_nxt;
      end
    end
  end

endmodule

// File: tb/tb_router_dest_rx.sv
// Directed bench for router_dest_rx: a queue-backed FIFO model feeds packets,
// a per-cycle monitor collects reads/captures/status for hand-computed checks.
module tb_router_dest_rx;

  logic       clk = 1'b0;
  logic       reset, vld_out, hold_in;
  logic [7:0] data_out;
  logic       read_enb, rx_data_vld, rx_sop, rx_eop, pkt_done, parity_err, abort, busy;
  logic [7:0] rx_data;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;

  int n_chk, n_fail, n_cyc, n_rd, first_rd, n_done, n_abort, perr_seen;
  int rd_cyc[$];
  logic [9:0] cap_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  router_dest_rx #(.READ_DELAY(2), .DW(8)) dut (
    .clk(clk), .reset(reset), .vld_out(vld_out), .data_out(data_out), .hold_in(hold_in),
    .read_enb(read_enb), .rx_data(rx_data), .rx_data_vld(rx_data_vld), .rx_sop(rx_sop),
    .rx_eop(rx_eop), .pkt_addr(pkt_addr), .pkt_len(pkt_len), .pkt_done(pkt_done),
    .parity_err(parity_err), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_cyc = 0; n_rd = 0; first_rd = -1; n_done = 0; n_abort = 0; perr_seen = 0;
    rd_cyc.delete(); cap_q.delete();
  endtask

  // One clock: monitor at negedge, then FIFO pops after the edge that sampled read_enb.
  task automatic cyc();
    logic re_s;
    @(negedge clk);
    n_cyc++;
    if (read_enb) begin
      n_rd++;
      rd_cyc.push_back(n_cyc);
      if (first_rd < 0) first_rd = n_cyc - 1;
    end
    if (rx_data_vld) cap_q.push_back({rx_sop, rx_eop, rx_data});
    if (pkt_done) begin n_done++; perr_seen = int'(parity_err); end
    if (abort) n_abort++;
    re_s = read_enb;
    @(posedge clk); #1;
    if (re_s && fifo_q.size() > 0) data_out = fifo_q.pop_front();
    vld_out = (fifo_q.size() != 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic mk_pkt(input int len, input int addr, input bit bad);
    logic [7:0] b, par;
    exp_q.delete();
    b = {len[5:0], addr[1:0]};
    par = b;
    exp_q.push_back(b);
    for (int i = 0; i < len; i++) begin
      b = 8'(8'h11 * (i + 1));
      par ^= b;
      exp_q.push_back(b);
    end
    exp_q.push_back(par ^ {7'd0, bad});
    foreach (exp_q[i]) fifo_q.push_back(exp_q[i]);
    vld_out = 1'b1;
  endtask

  task automatic verify(input string tag, input int len, input int addr, input int perr);
    int n, got;
    n = len + 2;
    check({tag, ".nrd"}, n_rd, n);
    check({tag, ".ncap"}, cap_q.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < cap_q.size()) ? int'(cap_q[i]) : -1;
      check({tag, ".byte"}, got, int'({1'(i == 0), 1'(i == n - 1), exp_q[i]}));
    end
    check({tag, ".len"}, int'(pkt_len), len);
    check({tag, ".addr"}, int'(pkt_addr), addr);
    check({tag, ".done"}, n_done, 1);
    check({tag, ".perr"}, perr_seen, perr);
    check({tag, ".abort"}, n_abort, 0);
    check({tag, ".busy"}, int'(busy), 0);
  endtask

  initial begin
    int eops;
    reset = 1'b0; vld_out = 1'b0; hold_in = 1'b0; data_out = '0;
    n_chk = 0; n_fail = 0;
    clr();
    #1 reset = 1'b1;
    run(3);
    check("rst.ctl", int'({read_enb, rx_data_vld, rx_sop, rx_eop, pkt_done, parity_err, abort, busy}), 0);
    check("rst.hdr", int'({pkt_addr, pkt_len, rx_data}), 0);
    reset = 1'b0;
    run(2);

    // nominal: len 3, addr 1
    clr(); mk_pkt(3, 1, 1'b0); run(16);
    check("nom.lat", first_rd, 3);
    verify("nom", 3, 1, 0);

    // zero-length packet
    clr(); mk_pkt(0, 2, 1'b0); run(12);
    verify("zero", 0, 2, 0);

    // corrupted parity byte
    clr(); mk_pkt(3, 1, 1'b1); run(16);
    verify("bad", 3, 1, 1);

    // backpressure for 4 cycles after the second read is issued
    clr(); mk_pkt(3, 1, 1'b0); run(4);
    hold_in = 1'b1; run(4);
    hold_in = 1'b0; run(16);
    check("bp.gap", (rd_cyc.size() >= 3) ? rd_cyc[2] - rd_cyc[1] - 1 : -1, 4);
    verify("bp", 3, 1, 0);

    // soft-reset of the FIFO after 2 of 5 reads
    clr(); mk_pkt(3, 1, 1'b0); run(4);
    hold_in = 1'b1; run(1);
    fifo_q.delete(); vld_out = 1'b0; run(6);
    hold_in = 1'b0; run(4);
    eops = 0;
    foreach (cap_q[i]) eops += int'(cap_q[i][8]);
    check("ab.abort", n_abort, 1);
    check("ab.done", n_done, 0);
    check("ab.nrd", n_rd, 2);
    check("ab.ncap", cap_q.size(), 2);
    check("ab.eop", eops, 0);
    check("ab.busy", int'(busy), 0);

    clr(); mk_pkt(5, 3, 1'b0); run(20);
    verify("post_ab", 5, 3, 0);

    // asynchronous reset in the middle of READ
    clr(); mk_pkt(3, 1, 1'b0); run(5);
    check("rm.pre", int'(read_enb), 1);
    #2 reset = 1'b1;
    #1;
    check("rm.rd", int'(read_enb), 0);
    check("rm.busy", int'(busy), 0);
    fifo_q.delete(); vld_out = 1'b0;
    run(2);
    reset = 1'b0;
    clr(); mk_pkt(2, 2, 1'b0); run(16);
    verify("post_rst", 2, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
